// File: rtl/melody_player.sv
// Square-wave melody sequencer: plays a 16-entry table of half-periods as
// timed notes separated by silent gaps, with pause, abort and looping.
module melody_player #(
  parameter int unsigned NOTE_TICKS = 12500000,
  parameter int unsigned GAP_TICKS  = 1250000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [3:0]  last_idx,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [19:0] wr_data,
  output logic        spk,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  localparam int unsigned DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int unsigned DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         last_q, last_d;
  logic [19:0]        hp_lat_q, hp_lat_d;
  logic [19:0]        hp_cnt_q, hp_cnt_d;
  logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
  logic               spk_q, spk_d;
  logic               done_q, done_d;
  logic [19:0]        table_q [16];

  // Table reads below see the pre-edge contents, so a same-cycle write loses to the latch.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hp_lat_d  = hp_lat_q;
    hp_cnt_d  = hp_cnt_q;
    dur_cnt_d = dur_cnt_q;
    spk_d     = spk_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && enable) begin
          state_d   = TONE;
          idx_d     = 4'd0;
          last_d    = last_idx;
          hp_lat_d  = table_q[0];
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          spk_d     = 1'b0;
        end
      end

      TONE: begin
        if (stop) begin
          state_d   = IDLE;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          spk_d     = 1'b0;
        end else if (enable) begin
          if (dur_cnt_q == NOTE_LAST) begin
            state_d   = GAP;
            hp_cnt_d  = '0;
            dur_cnt_d = '0;
            spk_d     = 1'b0;
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
            // A zero half-period is a rest: the tone counter never runs.
            if (hp_lat_q != 20'd0) begin
              if (hp_cnt_q == hp_lat_q - 20'd1) begin
                spk_d    = ~spk_q;
                hp_cnt_d = '0;
              end else begin
                hp_cnt_d = hp_cnt_q + 20'd1;
              end
            end
          end
        end
      end

      GAP: begin
        if (stop) begin
          state_d   = IDLE;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          spk_d     = 1'b0;
        end else if (enable) begin
          if (dur_cnt_q == GAP_LAST) begin
            dur_cnt_d = '0;
            hp_cnt_d  = '0;
            spk_d     = 1'b0;
            if (idx_q < last_q) begin
              state_d  = TONE;
              idx_d    = idx_q + 4'd1;
              hp_lat_d = table_q[idx_q + 4'd1];
            end else if (loop) begin
              state_d  = TONE;
              idx_d    = 4'd0;
              hp_lat_d = table_q[0];
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        hp_cnt_d  = '0;
        dur_cnt_d = '0;
        spk_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      last_q    <= 4'd0;
      hp_lat_q  <= '0;
      hp_cnt_q  <= '0;
      dur_cnt_q <= '0;
      spk_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hp_lat_q  <= hp_lat_d;
      hp_cnt_q  <= hp_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      spk_q     <= spk_d;
      done_q    <= done_d;
    end
  end

  // Pausing masks the pin but keeps spk_q, so playback resumes mid-phase.
  assign spk      = spk_q & enable;
  assign busy     = (state_q != IDLE);
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed/randomized bench for melody_player with NOTE_TICKS=20, GAP_TICKS=4;
// expected speaker output comes from a per-note tick model.
module tb_melody_player;

  localparam int NT = 20;
  localparam int GT = 4;

  logic        clk = 1'b0;
  logic        reset, enable, start, stop, loop, wr_en;
  logic [3:0]  last_idx, wr_addr;
  logic [19:0] wr_data;
  logic        spk, busy, done;
  logic [3:0]  note_idx;

  int    tests = 0;
  int    fails = 0;
  string phase = "init";

  melody_player #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .loop(loop), .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .spk(spk), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // k-th enabled cycle of a note: the square wave sits in half-period k/hp.
  function automatic logic model_spk(input int hp, input int k);
    if (hp == 0) return 1'b0;
    return ((k / hp) % 2) == 1;
  endfunction

  task automatic write_entry(input int addr, input int val);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = 20'(val);
    tick();
    wr_en = 1'b0;
  endtask

  // Walks one full note (TONE then GAP) starting at TONE cycle 0.
  // wr_at: cycle (0..NT+GT-1) at which table[idx] is rewritten with wr_val.
  task automatic play_note(input int idx, input int hp, input bit ends,
                           input int pause_at, input int wr_at, input int wr_val);
    for (int k = 0; k < NT; k++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("note_idx", 32'(note_idx), 32'(idx));
      chk("done", 32'(done), 32'd0);
      chk("spk", 32'(spk), 32'(model_spk(hp, k)));
      if (k == pause_at) begin
        enable = 1'b0;
        #1;
        for (int p = 0; p < 7; p++) begin
          chk("pause_spk", 32'(spk), 32'd0);
          chk("pause_idx", 32'(note_idx), 32'(idx));
          tick();
        end
        enable = 1'b1;
        #1;
        chk("resume_spk", 32'(spk), 32'(model_spk(hp, k)));
      end
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = 4'(idx); wr_data = 20'(wr_val);
      end
      tick();
      wr_en = 1'b0;
    end
    for (int g = 0; g < GT; g++) begin
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_idx", 32'(note_idx), 32'(idx));
      chk("gap_spk", 32'(spk), 32'd0);
      chk("gap_done", 32'(done), 32'd0);
      if (NT + g == wr_at) begin
        wr_en = 1'b1; wr_addr = 4'(idx); wr_data = 20'(wr_val);
      end
      tick();
      wr_en = 1'b0;
    end
    if (ends) begin
      chk("end_done", 32'(done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_spk", 32'(spk), 32'd0);
      tick();
      chk("done_once", 32'(done), 32'd0);
    end
  endtask

  task automatic pulse_start(input int last, input bit lp);
    last_idx = 4'(last); loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int h0, h1, h2, pa, wa, extra;
    reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    last_idx = 4'd0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 20'd0;
    tick();
    tick();
    phase = "reset";
    chk("spk", 32'(spk), 32'd0);
    chk("busy", 32'(busy), 32'd0);
    chk("done", 32'(done), 32'd0);
    chk("note_idx", 32'(note_idx), 32'd0);
    reset = 1'b0;

    phase = "single";
    write_entry(0, 3);
    pulse_start(0, 1'b0);
    play_note(0, 3, 1'b1, -1, -1, 0);

    phase = "sequence";
    write_entry(0, 2);
    write_entry(1, 0);
    write_entry(2, 5);
    pulse_start(2, 1'b0);
    play_note(0, 2, 1'b0, -1, -1, 0);
    play_note(1, 0, 1'b0, -1, -1, 0);
    play_note(2, 5, 1'b1, -1, -1, 0);

    phase = "loop";
    h0 = $urandom_range(1, 5);
    h1 = $urandom_range(0, 5);
    write_entry(0, h0);
    write_entry(1, h1);
    pulse_start(1, 1'b1);
    play_note(0, h0, 1'b0, -1, -1, 0);
    play_note(1, h1, 1'b0, -1, -1, 0);
    play_note(0, h0, 1'b0, -1, -1, 0);
    extra = $urandom_range(1, 10);
    for (int i = 0; i < extra; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_spk", 32'(spk), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    tick();
    chk("stop_done2", 32'(done), 32'd0);
    loop = 1'b0;

    phase = "pause";
    h0 = $urandom_range(1, 6);
    pa = $urandom_range(3, 15);
    write_entry(0, h0);
    pulse_start(0, 1'b0);
    play_note(0, h0, 1'b1, pa, -1, 0);

    phase = "write_play";
    h0 = $urandom_range(1, 4);
    h1 = $urandom_range(1, 4) + 4;
    h2 = $urandom_range(1, 3);
    wa = $urandom_range(1, 18);
    write_entry(0, h0);
    pulse_start(0, 1'b1);
    play_note(0, h0, 1'b0, -1, wa, h1);
    play_note(0, h1, 1'b0, -1, NT + GT - 1, h2);
    play_note(0, h1, 1'b0, -1, -1, 0);
    play_note(0, h2, 1'b0, -1, -1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    loop = 1'b0;

    phase = "reset_gap";
    write_entry(0, $urandom_range(1, 6));
    pulse_start(0, 1'b0);
    for (int i = 0; i < NT + 2; i++) tick();
    chk("pre_busy", 32'(busy), 32'd1);
    reset = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 20'd9;
    tick();
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("spk", 32'(spk), 32'd0);
    chk("busy", 32'(busy), 32'd0);
    chk("done", 32'(done), 32'd0);
    chk("note_idx", 32'(note_idx), 32'd0);
    tick();
    chk("done_after", 32'(done), 32'd0);
    pulse_start(0, 1'b0);
    play_note(0, 0, 1'b1, -1, -1, 0);

    phase = "start_stop";
    write_entry(0, 2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("busy", 32'(busy), 32'd0);
    tick();
    chk("busy2", 32'(busy), 32'd0);
    chk("spk", 32'(spk), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
